// File: rtl/prom_fuse_programmer_if.sv
// Command, status and PROM pin bundle for the fuse programmer.
// The master side is the board: it issues requests and returns the chip data pins.
interface prom_fuse_programmer_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 9,
  parameter int SELECT_WIDTH  = 4
);
  logic                     start;
  logic [ADDRESS_WIDTH-1:0] address_in;
  logic [DATA_WIDTH-1:0]    data_in;
  logic [DATA_WIDTH-1:0]    data_line_in;
  logic [ADDRESS_WIDTH-1:0] address_line;
  logic [SELECT_WIDTH-1:0]  chip_select;
  logic                     vpp_enable;
  logic [DATA_WIDTH-1:0]    bit_pulse;
  logic                     busy;
  logic                     done;
  logic                     error;
  logic [1:0]               error_code;
  logic [DATA_WIDTH-1:0]    data_read;

  modport master (
    output start, address_in, data_in, data_line_in,
    input  address_line, chip_select, vpp_enable, bit_pulse,
           busy, done, error, error_code, data_read
  );

  modport slave (
    input  start, address_in, data_in, data_line_in,
    output address_line, chip_select, vpp_enable, bit_pulse,
           busy, done, error, error_code, data_read
  );
endinterface

// File: rtl/prom_fuse_programmer.sv
// Burns one word into a bipolar fuse PROM: blank check, then per-bit Vpp-gated
// fuse pulses, each followed by a read-back verify with a bounded retry count.
module prom_fuse_programmer #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDRESS_WIDTH   = 9,
  parameter int SELECT_WIDTH    = 4,
  parameter int SETUP_CYCLES    = 50,
  parameter int PULSE_CYCLES    = 500,
  parameter int RECOVERY_CYCLES = 100,
  parameter int MAX_PULSES      = 4
) (
  input logic                    clk,
  input logic                    reset,
  prom_fuse_programmer_if.slave  bus
);

  localparam int MAX_WAIT = (SETUP_CYCLES > PULSE_CYCLES)
                          ? ((SETUP_CYCLES > RECOVERY_CYCLES) ? SETUP_CYCLES : RECOVERY_CYCLES)
                          : ((PULSE_CYCLES > RECOVERY_CYCLES) ? PULSE_CYCLES : RECOVERY_CYCLES);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam int PC_W  = $clog2(MAX_PULSES + 1);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST    = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST    = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECOVERY_LAST = CNT_W'(RECOVERY_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, BLANK_READ, VPP_ON, PULSE, RECOVER, VERIFY, DONE, FAIL
  } state_t;

  typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_NOT_BLANK, ERR_NO_BLOW} err_t;

  // Every piece of state lives in one registered record; outputs come straight from it.
  typedef struct packed {
    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic [PC_W-1:0]          pulses;
    logic [IDX_W-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0]    target;
    logic [ADDRESS_WIDTH-1:0] address_line;
    logic [SELECT_WIDTH-1:0]  chip_select;
    logic                     vpp_enable;
    logic [DATA_WIDTH-1:0]    bit_pulse;
    logic                     busy;
    logic                     done;
    logic                     error;
    err_t                     error_code;
    logic [DATA_WIDTH-1:0]    data_read;
  } regs_t;

  regs_t                 r, r_next;
  logic                  go_vpp, go_done, go_fail;
  err_t                  fail_code;
  logic [IDX_W-1:0]      next_idx;
  logic [DATA_WIDTH-1:0] pending;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [DATA_WIDTH-1:0] v);
    lowest_set = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--)
      if (v[i]) lowest_set = IDX_W'(i);
  endfunction

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    r_next    = r;
    r_next.cnt = r.cnt + CNT_W'(1);
    go_vpp    = 1'b0;
    go_done   = 1'b0;
    go_fail   = 1'b0;
    fail_code = ERR_NONE;
    next_idx  = r.bit_idx;
    pending   = r.target & ~bus.data_line_in;

    case (r.state)
      IDLE: begin
        r_next.cnt = '0;
        if (bus.start) begin
          r_next.state        = BLANK_READ;
          r_next.target       = bus.data_in;
          r_next.address_line = bus.address_in;
          r_next.chip_select  = '0;
          r_next.busy         = 1'b1;
          r_next.error        = 1'b0;
          r_next.error_code   = ERR_NONE;
        end
      end
      BLANK_READ, VERIFY: begin
        if (r.cnt == SETUP_LAST) begin
          r_next.data_read = bus.data_line_in;
          r_next.cnt       = '0;
          if (r.state == BLANK_READ && |(bus.data_line_in & ~r.target)) begin
            go_fail   = 1'b1;
            fail_code = ERR_NOT_BLANK;
          end else if (r.state == BLANK_READ || bus.data_line_in[r.bit_idx]) begin
            // Current bit confirmed (or fresh start): move on to the lowest unburnt bit.
            if (pending == '0) begin
              go_done = 1'b1;
            end else begin
              go_vpp        = 1'b1;
              next_idx      = lowest_set(pending);
              r_next.pulses = '0;
            end
          end else if (r.pulses < PC_W'(MAX_PULSES)) begin
            go_vpp = 1'b1;
          end else begin
            go_fail   = 1'b1;
            fail_code = ERR_NO_BLOW;
          end
        end
      end
      VPP_ON: begin
        if (r.cnt == SETUP_LAST) begin
          r_next.state     = PULSE;
          r_next.bit_pulse = DATA_WIDTH'(1) << r.bit_idx;
          r_next.cnt       = '0;
        end
      end
      PULSE: begin
        if (r.cnt == PULSE_LAST) begin
          r_next.state      = RECOVER;
          r_next.bit_pulse  = '0;
          r_next.vpp_enable = 1'b0;
          r_next.pulses     = r.pulses + PC_W'(1);
          r_next.cnt        = '0;
        end
      end
      RECOVER: begin
        if (r.cnt == RECOVERY_LAST) begin
          r_next.state       = VERIFY;
          r_next.chip_select = '0;
          r_next.cnt         = '0;
        end
      end
      DONE: begin
        r_next.state = IDLE;
        r_next.done  = 1'b0;
        r_next.busy  = 1'b0;
        r_next.cnt   = '0;
      end
      FAIL: begin
        r_next.state = IDLE;
        r_next.busy  = 1'b0;
        r_next.cnt   = '0;
      end
      default: r_next.state = IDLE;
    endcase

    // Deselecting the chip during Vpp keeps its outputs off the pins being pulsed.
    if (go_vpp) begin
      r_next.state       = VPP_ON;
      r_next.vpp_enable  = 1'b1;
      r_next.chip_select = '1;
      r_next.bit_idx     = next_idx;
    end
    if (go_done) begin
      r_next.state       = DONE;
      r_next.done        = 1'b1;
      r_next.chip_select = '1;
    end
    if (go_fail) begin
      r_next.state       = FAIL;
      r_next.error       = 1'b1;
      r_next.error_code  = fail_code;
      r_next.vpp_enable  = 1'b0;
      r_next.bit_pulse   = '0;
      r_next.chip_select = '1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r             <= '0;
      r.state       <= IDLE;
      r.chip_select <= '1;
    end else begin
      r <= r_next;
    end
  end

  assign bus.address_line = r.address_line;
  assign bus.chip_select  = r.chip_select;
  assign bus.vpp_enable   = r.vpp_enable;
  assign bus.bit_pulse    = r.bit_pulse;
  assign bus.busy         = r.busy;
  assign bus.done         = r.done;
  assign bus.error        = r.error;
  assign bus.error_code   = r.error_code;
  assign bus.data_read    = r.data_read;

endmodule

// File: tb/tb_prom_fuse_programmer.sv
// Bench for prom_fuse_programmer: a fuse-PROM chip model plus an expected
// per-cycle output timeline built from phase lengths and the burn outcome.
module tb_prom_fuse_programmer;

  localparam int DW = 8, AW = 9, SW = 4;
  localparam int SETUP = 50, PULSE = 500, RECOV = 100, MAXP = 4;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prom_fuse_programmer_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .SELECT_WIDTH(SW)) bus();

  prom_fuse_programmer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    code;
    logic          vpp;
    logic [DW-1:0] bp;
    logic [SW-1:0] cs;
    logic [AW-1:0] addr;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          idle_exp;
  bit            model_on = 1'b0;
  logic [DW-1:0] last_rd;
  int            n_compared = 0;
  int            n_mismatched = 0;

  // Chip model: one word at op_addr; a fuse opens once its pulse count reaches need_abs.
  logic [AW-1:0] op_addr = '0;
  logic [DW-1:0] op_init = '0;
  int            need_abs[DW];
  int            need_rel[DW];
  int            pulses_per_bit[DW];
  logic [DW-1:0] blown;

  always_comb begin
    blown = '0;
    for (int i = 0; i < DW; i++) blown[i] = (pulses_per_bit[i] >= need_abs[i]);
  end

  assign bus.data_line_in = (bus.chip_select == '0 && bus.address_line == op_addr)
                          ? (op_init | blown) : '1;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Pulse monitor: counts finished fuse pulses, their width, Vpp cycles and done pulses.
  logic [DW-1:0] prev_bp = '0;
  logic [DW-1:0] pulse_log[$];
  int width = 0, last_width = 0, vpp_cycles = 0, done_total = 0;

  always @(negedge clk) begin
    if (bus.vpp_enable) vpp_cycles++;
    if (bus.done) done_total++;
    if (bus.bit_pulse != '0) width++;
    if (prev_bp != '0 && bus.bit_pulse != prev_bp) begin
      for (int i = 0; i < DW; i++) if (prev_bp[i]) pulses_per_bit[i]++;
      pulse_log.push_back(prev_bp);
      last_width = width;
      width = 0;
    end
    prev_bp = bus.bit_pulse;
  end

  // Single compare process: every cycle against the expected timeline or the idle state.
  always @(negedge clk) begin
    exp_t e, a;
    if (model_on && !reset) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : idle_exp;
      a.busy  = bus.busy;
      a.done  = bus.done;
      a.error = bus.error;
      a.code  = bus.error_code;
      a.vpp   = bus.vpp_enable;
      a.bp    = bus.bit_pulse;
      a.cs    = bus.chip_select;
      a.addr  = bus.address_line;
      a.rd    = bus.data_read;
      if (!e.busy) begin
        a.addr = '0;
        e.addr = '0;
      end
      check("cycle_outputs", 64'(a), 64'(e));
    end
  end

  function automatic int lowest(input logic [DW-1:0] v);
    for (int i = 0; i < DW; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic push_n(input exp_t e, input int n);
    repeat (n) exp_q.push_back(e);
  endtask

  // Expected timeline: blank read, then per pulse Vpp setup / pulse / recovery / verify.
  task automatic build(input logic [AW-1:0] addr, input logic [DW-1:0] init, input logic [DW-1:0] target);
    exp_t e;
    logic [DW-1:0] cur, pend;
    int b;
    bit ok;
    e = '0;
    e.busy = 1'b1;
    e.addr = addr;
    e.rd   = last_rd;
    push_n(e, SETUP);
    e.rd = init;
    cur  = init;
    if ((init & ~target) != '0) begin
      e.error = 1'b1;
      e.code  = 2'd1;
      e.cs    = '1;
      push_n(e, 1);
    end else begin
      ok   = 1'b1;
      pend = target & ~cur;
      while (ok && pend != '0) begin
        b = lowest(pend);
        for (int p = 1; p <= MAXP; p++) begin
          e.cs = '1; e.vpp = 1'b1; push_n(e, SETUP);
          e.bp = DW'(1) << b;       push_n(e, PULSE);
          e.vpp = 1'b0; e.bp = '0;  push_n(e, RECOV);
          e.cs = '0;                push_n(e, SETUP);
          if (p >= need_rel[b]) cur[b] = 1'b1;
          e.rd = cur;
          if (cur[b]) break;
        end
        if (!cur[b]) ok = 1'b0;
        pend = target & ~cur;
      end
      e.cs = '1;
      if (ok) e.done = 1'b1;
      else begin
        e.error = 1'b1;
        e.code  = 2'd2;
      end
      push_n(e, 1);
    end
    last_rd       = e.rd;
    idle_exp      = e;
    idle_exp.busy = 1'b0;
    idle_exp.done = 1'b0;
  endtask

  task automatic start_op(input logic [AW-1:0] addr, input logic [DW-1:0] init, input logic [DW-1:0] target);
    @(negedge clk);
    op_addr = addr;
    op_init = init;
    for (int i = 0; i < DW; i++) need_abs[i] = pulses_per_bit[i] + need_rel[i];
    bus.address_in = addr;
    bus.data_in    = target;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    build(addr, init, target);
  endtask

  task automatic wait_op();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      check("op_time_budget", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic set_need(input int n);
    for (int i = 0; i < DW; i++) need_rel[i] = n;
  endtask

  task automatic reset_idle();
    idle_exp    = '0;
    idle_exp.cs = '1;
    last_rd     = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, d0, v0;
    logic [AW-1:0] ra;
    logic [DW-1:0] rt, ri;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.address_in = '0;
    bus.data_in    = '0;
    for (int i = 0; i < DW; i++) begin
      need_abs[i] = NEVER;
      pulses_per_bit[i] = 0;
    end
    set_need(1);
    reset_idle();

    #12;
    check("reset_chip_select", 64'(bus.chip_select), 64'hF);
    check("reset_address",     64'(bus.address_line), 64'h0);
    check("reset_vpp_pulse",   64'({bus.vpp_enable, bus.bit_pulse}), 64'h0);
    check("reset_status",      64'({bus.busy, bus.done, bus.error, bus.error_code, bus.data_read}), 64'h0);
    @(negedge clk);
    reset    = 1'b0;
    model_on = 1'b1;
    repeat (3) @(negedge clk);

    // Blank chip, 0x81 at 0x1A5: bit0 then bit7, one 500-cycle pulse each.
    p0 = pulse_log.size(); d0 = done_total;
    start_op(9'h1A5, 8'h00, 8'h81);
    wait_op();
    check("t1_pulse_count", 64'(pulse_log.size() - p0), 64'd2);
    check("t1_first_pulse", 64'(pulse_log[p0]), 64'h01);
    check("t1_second_pulse", 64'(pulse_log[p0+1]), 64'h80);
    check("t1_pulse_width", 64'(last_width), 64'd500);
    check("t1_done_pulses", 64'(done_total - d0), 64'd1);
    check("t1_data_read", 64'(bus.data_read), 64'h81);
    check("t1_error", 64'(bus.error), 64'd0);
    check("t1_chip_word", 64'(op_init | blown), 64'h81);

    // Chip already 0x04, target 0x05: only bit0 needs a pulse.
    p0 = pulse_log.size(); d0 = done_total;
    start_op(9'h033, 8'h04, 8'h05);
    wait_op();
    check("t2_pulse_count", 64'(pulse_log.size() - p0), 64'd1);
    check("t2_pulse_bit", 64'(pulse_log[p0]), 64'h01);
    check("t2_done_pulses", 64'(done_total - d0), 64'd1);

    // Chip 0x10, target 0x01: not blank, no Vpp at all.
    v0 = vpp_cycles;
    start_op(9'h100, 8'h10, 8'h01);
    wait_op();
    check("t3_error", 64'({bus.error, bus.error_code}), 64'b101);
    check("t3_vpp_cycles", 64'(vpp_cycles - v0), 64'd0);
    check("t3_data_read", 64'(bus.data_read), 64'h10);

    // Bit3 never opens: four pulses, then error code 2 and busy low.
    need_rel[3] = NEVER;
    p0 = pulse_log.size();
    start_op(9'h0AA, 8'h00, 8'h08);
    wait_op();
    need_rel[3] = 1;
    check("t4_pulse_count", 64'(pulse_log.size() - p0), 64'd4);
    check("t4_error", 64'({bus.error, bus.error_code}), 64'b110);
    check("t4_busy", 64'(bus.busy), 64'd0);

    // Target 0 on a blank chip: done straight after blank read, no Vpp.
    v0 = vpp_cycles; d0 = done_total;
    start_op(9'h1FF, 8'h00, 8'h00);
    wait_op();
    check("t5_vpp_cycles", 64'(vpp_cycles - v0), 64'd0);
    check("t5_done_pulses", 64'(done_total - d0), 64'd1);
    check("t5_error_cleared", 64'(bus.error), 64'd0);

    // Reset 100 cycles into the first pulse drops Vpp and the pulse immediately.
    start_op(9'h055, 8'h00, 8'h02);
    repeat (2 * SETUP + 100) @(posedge clk);
    #2;
    model_on = 1'b0;
    exp_q.delete();
    check("t6_in_pulse", 64'({bus.vpp_enable, bus.bit_pulse}), 64'h102);
    reset = 1'b1;
    #1;
    check("t6_reset_vpp_pulse", 64'({bus.vpp_enable, bus.bit_pulse}), 64'h0);
    check("t6_reset_select_busy", 64'({bus.chip_select, bus.busy}), 64'b11110);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    reset_idle();
    model_on = 1'b1;
    repeat (2) @(negedge clk);

    // Extra starts and changed inputs while busy must not disturb the latched request.
    start_op(9'h0F0, 8'h00, 8'h24);
    for (int k = 0; k < 5; k++) begin
      repeat (150) @(negedge clk);
      if (exp_q.size() > 20) begin
        bus.start      = 1'b1;
        bus.data_in    = DW'($urandom);
        bus.address_in = AW'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
    wait_op();
    check("t7_chip_word", 64'(op_init | blown), 64'h24);
    check("t7_data_read", 64'(bus.data_read), 64'h24);

    // Random words, partially pre-burnt chips, stubborn fuses and occasional conflicts.
    for (int n = 0; n < 16; n++) begin
      ra = AW'($urandom_range(0, (1 << AW) - 1));
      rt = DW'($urandom) & DW'($urandom);
      ri = rt & DW'($urandom);
      if ($urandom_range(0, 4) == 0) ri = ri | (DW'(1) << $urandom_range(0, DW - 1));
      for (int i = 0; i < DW; i++)
        need_rel[i] = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, 3));
      start_op(ra, ri, rt);
      wait_op();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
